sudoku_ssd_scanner: RTL



---
 rtl/sudoku_ssd_scanner.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sudoku_ssd_scanner.sv
// Seven-segment scanner for the Sudoku solver: 4-digit common-anode multiplexing with blink for editable cells.
// Optional SSD_ANTIGHOST_EN blanks the anodes for the first 4 cycles of every digit slot.
module sudoku_ssd_scanner #(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 25
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Load,
  input  logic       Forward,
  input  logic       Check,
  input  logic       Back,
  input  logic       Disp,
  input  logic       Fail,
  input  logic [3:0] Row,
  input  logic [3:0] Col,
  input  logic [3:0] OutputValue,
  input  logic [3:0] OutputAttempt,
  input  logic       OutputFixed,
  output logic [3:0] An,
  output logic [7:0] Ca
);

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;
  localparam logic [7:0] GLYPH_F     = 8'h8E;
  localparam logic [7:0] GLYPH_A     = 8'h88;
  localparam logic [7:0] GLYPH_I     = 8'hF9;
  localparam logic [7:0] GLYPH_L     = 8'hC7;
  localparam logic [7:0] GLYPH_D     = 8'hA1;
  localparam logic [7:0] DP_MASK     = 8'h7F;

  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [BLINK_BITS-1:0]   blink_cnt;
  logic [1:0]              sel;
  logic                    blink_phase;
  logic [6:0]              flags;
  logic                    flags_onehot;
  logic                    slot_blank;
  logic [7:0]              d3_p0, d2_p0, d1_p0, d0_p0;
  logic [3:0]              an_p0;
  logic [7:0]              ca_p0;

  function automatic logic [7:0] glyph_digit(input logic [3:0] d);
    case (d)
      4'd1:    glyph_digit = 8'hF9;
      4'd2:    glyph_digit = 8'hA4;
      4'd3:    glyph_digit = 8'hB0;
      4'd4:    glyph_digit = 8'h99;
      4'd5:    glyph_digit = 8'h92;
      4'd6:    glyph_digit = 8'h82;
      4'd7:    glyph_digit = 8'hF8;
      4'd8:    glyph_digit = 8'h80;
      4'd9:    glyph_digit = 8'h90;
      default: glyph_digit = GLYPH_BLANK;
    endcase
  endfunction

  // Row/Col are 0-based internally but shown 1-based to the player.
  function automatic logic [7:0] rowcol_glyph(input logic [3:0] v);
    if (v <= 4'd8) rowcol_glyph = glyph_digit(v + 4'd1);
    else           rowcol_glyph = GLYPH_DASH;
  endfunction

  function automatic logic [7:0] value_glyph(input logic [3:0] v);
    if (v == 4'd0)      value_glyph = GLYPH_BLANK;
    else if (v <= 4'd9) value_glyph = glyph_digit(v);
    else                value_glyph = GLYPH_DASH;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign sel          = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2];
  assign blink_phase  = blink_cnt[BLINK_BITS-1];
  assign flags        = {Init, Load, Forward, Check, Back, Disp, Fail};
  assign flags_onehot = (flags != 7'd0) && ((flags & (flags - 7'd1)) == 7'd0);

`ifdef SSD_ANTIGHOST_EN
  // Keep the anode dark while the new cathode pattern settles.
  assign slot_blank = (refresh_cnt[REFRESH_BITS-3:0] < (REFRESH_BITS-2)'(4));
`else
  assign slot_blank = 1'b0;
`endif

  // Stage p0: per-state digit contents and digit selection
  always_comb begin
    d3_p0 = GLYPH_BLANK;
    d2_p0 = GLYPH_BLANK;
    d1_p0 = GLYPH_BLANK;
    d0_p0 = GLYPH_BLANK;
    if (Fail) begin
      d3_p0 = GLYPH_F;
      d2_p0 = GLYPH_A;
      d1_p0 = GLYPH_I;
      d0_p0 = GLYPH_L;
    end else if (!Init) begin
      d3_p0 = rowcol_glyph(Row);
      d2_p0 = rowcol_glyph(Col);
      d1_p0 = value_glyph(OutputValue);
      if (OutputFixed) d1_p0 = d1_p0 & DP_MASK;
      if (Load && !OutputFixed && blink_phase) d1_p0 = GLYPH_BLANK;
      if (Forward || Check || Back) d0_p0 = value_glyph(OutputAttempt);
      else if (Disp)                d0_p0 = GLYPH_D;
    end
  end

  always_comb begin
    an_p0 = 4'b1111;
    ca_p0 = GLYPH_BLANK;
    if (flags_onehot) begin
      an_p0 = slot_blank ? 4'b1111 : ~(4'b0001 << sel);
      case (sel)
        2'd0:    ca_p0 = d0_p0;
        2'd1:    ca_p0 = d1_p0;
        2'd2:    ca_p0 = d2_p0;
        default: ca_p0 = d3_p0;
      endcase
    end
  end

  // Stage p1: registered pins
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      An <= 4'b1111;
      Ca <= GLYPH_BLANK;
    end else begin
      An <= an_p0;
      Ca <= ca_p0;
    end
  end

endmodule
